button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Multi-channel debounce controller and event arbiter for the front-panel button inputs. It oversamples N raw, asynchronous button lines on one shared sample tick and filters each line into a clean level. Each level transition becomes an event; a round-robin arbiter funnels the events onto a single valid/ready stream for the downstream command logic.

## Interface
- `N_CH`, 4: number of button channels, 2..16.
- `TICK_DIV`, 1000: clock cycles per sample tick, ≥2.
- `STABLE_TICKS`, 8: consecutive differing samples required to flip a level, 1..255.
- `i_clk` input 1: single clock, all logic on posedge.
- `i_rst` input 1: reset, synchronous, active-low.
- `i_data` input N_CH: raw asynchronous button lines.
- `o_level` output N_CH: debounced levels.
- `o_evt_valid` output 1: event available.
- `i_evt_ready` input 1: consumer accepts the event.
- `o_evt_ch` output $clog2(N_CH): channel index of the event.
- `o_evt_rise` output 1: 1 = press (0→1), 0 = release.
- `o_overrun` output N_CH: sticky; an event was overwritten before it was granted.
- `i_clr_overrun` input 1: clears all `o_overrun` bits on the next edge.

## Operation
- **Input sync.** Each `i_data` bit passes through a 2-flop synchronizer to give `sync[i]`.
- **Tick generator.** Counter 0..TICK_DIV-1; `tick` pulses for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- **Per-channel filter, on each tick:**
  - If `sync[i] != o_level[i]`, increment `cnt[i]`; otherwise clear `cnt[i]`.
  - When the increment would reach STABLE_TICKS, toggle `o_level[i]`, clear `cnt[i]` and raise `edge[i]` for one cycle.
  - Counter width is $clog2(STABLE_TICKS+1); it never wraps.
- **Pending slots.** Each channel has `pend[i]` and `pol[i]`.
  - `edge[i]` sets `pend[i]=1` and `pol[i]=new level`.
  - If `pend[i]` was already set and not granted that cycle, `o_overrun[i]` is set and the newer polarity wins.
- **Arbiter.**
  - The output register is free when `!o_evt_valid || i_evt_ready`.
  - When free and any `pend` is set, grant the first pending channel searching upward from `last+1`, modulo N_CH.
  - A grant loads `o_evt_ch` and `o_evt_rise`, sets `o_evt_valid`, clears that `pend` and updates `last`.
  - When free and nothing is pending, `o_evt_valid` drops to 0.
- **Handshake.**
  - While `o_evt_valid=1 && i_evt_ready=0`, the payload is held stable.
  - Back-to-back transfers run at one event per cycle.
- **Simultaneous edge and grant on the same channel.** The grant takes the old polarity. `pend` stays set with the new polarity. No overrun is flagged.
- **Simultaneous clear and overrun.** When `i_clr_overrun` and a new overrun hit in the same cycle, the set wins.
- **Reset mid-operation.** Every pending or in-flight event is discarded; nothing is replayed after reset.

## Timing
- **Reset values:**
  - `o_level=0`, `o_evt_valid=0`, `o_evt_ch=0`, `o_evt_rise=0`, `o_overrun=0`.
  - `cnt=0`, `pend=0`, tick counter 0, `last=N_CH-1` (so channel 0 has first priority).
  - Synchronizer flops reset to 0.
- **Pin to level.** 2 sync cycles, then STABLE_TICKS ticks. `o_level` changes the cycle after the qualifying tick.
- **Level to event.** `pend` is set in the same edge as the `o_level` update. `o_evt_valid` rises one cycle later if the output register is free.
- **Fairness.** A continuously pending channel waits at most N_CH-1 grants.

## Configuration
- `BUTTON_EVENT_ARBITER_RELEASE_EN`:
  - **Defined:** both press and release edges produce events.
  - **Undefined:** only 0→1 edges set `pend`, and `o_evt_rise` is constant 1. `o_level` is still updated on both edges, and overrun still applies to press events.

## Structure
- **Package `button_pkg`:**
  - `evt_t` struct holding `ch` and `rise`.
  - Constant `SYNC_STAGES=2`.
  - Function `rr_next(pend, last)` for the round-robin search.
- **Sub-module `debounce_channel`:** synchronizer, stability counter and level register. It takes the shared `tick` and outputs `level` and `edge`, and is instantiated N_CH times.
- **Top level** holds the tick generator, pending slots, arbiter and output register.

## Test plan
Bench parameters: N_CH=4, TICK_DIV=4, STABLE_TICKS=3.
1. **Clean press:** hold ch1 high with ready=1. `o_level[1]` rises 2 + 3×4 cycles (±tick phase) after the pin; a single event follows with ch=1, rise=1.
2. **Bounce:** toggle ch0 every 5 cycles for 40 cycles, then hold 1. There is no event during the bounce and exactly one rise event after settling.
3. **Simultaneous press, ready=0:** press ch0, ch2 and ch3 on the same cycle, then raise ready. Events come out in order 0, 2, 3, one per cycle, with the payload held while ready=0.
4. **Overrun:** ch2 press then release with ready=0 throughout.
   - With RELEASE_EN: `o_overrun[2]=1` and the granted event is rise=0.
   - Then `i_clr_overrun` clears it.
5. **Reset mid-stream:** assert `i_rst=0` while `o_evt_valid=1` and two events are pending. Outputs return to reset values; no event appears after release until a new edge.
6. **Round-robin fairness:** keep ch0 and ch3 re-pending continuously. Grants alternate 0 and 3 and never starve ch3.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types, constants and the round-robin search helper for the button event arbiter.
package button_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_CH      = 16;

  typedef struct packed {
    logic [3:0] ch;
    logic       rise;
  } evt_t;

  // Channels above N_CH are zero-padded, so a mod-16 search yields the same winner as mod N_CH.
  function automatic logic [3:0] rr_next(input logic [MAX_CH-1:0] pend, input logic [3:0] last);
    logic [3:0] idx;
    logic       found;
    rr_next = last;
    found   = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = last + 4'(k);
      if (!found && pend[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// One button line: 2-flop synchronizer and tick-qualified stability filter; level flips after
// STABLE_TICKS consecutive differing ticks, and edge_hit pulses on that same tick (before the flip).
module debounce_channel
  import button_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic tick,
  output logic level,
  output logic edge_hit
);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign edge_hit = tick && (sync != level) && (cnt == CW'(STABLE_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_data};
      if (edge_hit) begin
        level <= ~level;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= (sync != level) ? cnt + CW'(1) : '0;
      end
    end
  end
endmodule

// File: rtl/button_event_arbiter.sv
// Debounced buttons -> per-channel pending slots -> round-robin onto one valid/ready event stream.
// Release events are reported only when BUTTON_EVENT_ARBITER_RELEASE_EN is defined.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CH-1:0]         i_data,
  output logic [N_CH-1:0]         o_level,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [$clog2(N_CH)-1:0] o_evt_ch,
  output logic                    o_evt_rise,
  output logic [N_CH-1:0]         o_overrun,
  input  logic                    i_clr_overrun
);
  localparam int CHW = $clog2(N_CH);
  localparam int TW  = $clog2(TICK_DIV);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_CH-1:0] edge_hit;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] pend_nx;
  logic [N_CH-1:0] ovr_set;
  logic [CHW-1:0]  last;
  logic [CHW-1:0]  gnt_ch;
  logic            free;
  logic            grant;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_data   (i_data[g]),
      .tick     (tick),
      .level    (o_level[g]),
      .edge_hit (edge_hit[g])
    );
  end

  assign free   = !o_evt_valid || i_evt_ready;
  assign grant  = free && (|pend);
  assign gnt_ch = CHW'(rr_next(16'(pend), 4'(last)));

  // An edge landing on the channel being granted re-arms the slot without counting as overrun.
  always_comb begin
    pend_nx = pend;
    ovr_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant && gnt_ch == CHW'(i)) pend_nx[i] = 1'b0;
      if (ev[i]) begin
        pend_nx[i] = 1'b1;
        if (pend[i] && !(grant && gnt_ch == CHW'(i))) ovr_set[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pend        <= '0;
      last        <= CHW'(N_CH - 1);
      o_evt_valid <= 1'b0;
      o_evt_ch    <= '0;
      o_overrun   <= '0;
    end else begin
      pend      <= pend_nx;
      o_overrun <= (o_overrun & ~{N_CH{i_clr_overrun}}) | ovr_set;
      if (free) o_evt_valid <= grant;
      if (grant) begin
        o_evt_ch <= gnt_ch;
        last     <= gnt_ch;
      end
    end
  end

`ifdef BUTTON_EVENT_ARBITER_RELEASE_EN
  logic [N_CH-1:0] pol;

  assign ev = edge_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pol        <= '0;
      o_evt_rise <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ev[i]) pol[i] <= ~o_level[i];
      end
      if (grant) o_evt_rise <= pol[gnt_ch];
    end
  end
`else
  assign ev         = edge_hit & ~o_level;
  assign o_evt_rise = 1'b1;
`endif
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with N_CH=4, TICK_DIV=4, STABLE_TICKS=3.
module tb_button_event_arbiter;
  import button_pkg::*;

`ifdef BUTTON_EVENT_ARBITER_RELEASE_EN
  localparam int   REL_EVTS = 1;
  localparam logic RST_RISE = 1'b0;
  localparam logic OVR_RISE = 1'b0;
`else
  localparam int   REL_EVTS = 0;
  localparam logic RST_RISE = 1'b1;
  localparam logic OVR_RISE = 1'b1;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_data = '0;
  logic       i_evt_ready = 1'b0;
  logic       i_clr_overrun = 1'b0;
  logic [3:0] o_level;
  logic       o_evt_valid;
  logic [1:0] o_evt_ch;
  logic       o_evt_rise;
  logic [3:0] o_overrun;

  int   n_checks = 0;
  int   n_fail = 0;
  evt_t evq[$];

  button_event_arbiter #(.N_CH(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .o_level       (o_level),
    .o_evt_valid   (o_evt_valid),
    .i_evt_ready   (i_evt_ready),
    .o_evt_ch      (o_evt_ch),
    .o_evt_rise    (o_evt_rise),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    evt_t e;
    if (i_rst && o_evt_valid && i_evt_ready) begin
      e.ch   = 4'(o_evt_ch);
      e.rise = o_evt_rise;
      evq.push_back(e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_lvl(input int ch, input logic val, output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      if (n < 0) begin
        step(1);
        if (o_level[ch] === val) n = k;
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      if (n < 0) begin
        step(1);
        if (o_evt_valid === 1'b1) n = k;
      end
    end
  endtask

  task automatic settle_all();
    i_data = '0;
    i_evt_ready = 1'b1;
    i_clr_overrun = 1'b0;
    step(30);
    evq.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    step(3);
    n_checks++; if (o_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b want 0000", o_level); end
    n_checks++; if (o_evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_evt_valid); end
    n_checks++; if (o_evt_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", o_evt_ch); end
    n_checks++; if (o_evt_rise !== RST_RISE) begin n_fail++; $display("FAIL reset_rise: got %b want %b", o_evt_rise, RST_RISE); end
    n_checks++; if (o_overrun !== 4'b0000) begin n_fail++; $display("FAIL reset_overrun: got %b want 0000", o_overrun); end
    i_rst = 1'b1;
    step(20);
    n_checks++; if (o_evt_valid !== 1'b0 || o_level !== 4'b0000) begin n_fail++; $display("FAIL idle_after_reset: valid=%b level=%b want 0/0000", o_evt_valid, o_level); end
  endtask

  task automatic test_simul_press();
    int n;
    i_evt_ready = 1'b0;
    evq.delete();
    i_data = 4'b1101;
    wait_valid(n);
    n_checks++; if (n < 0 || o_evt_ch !== 2'd0 || o_evt_rise !== 1'b1) begin n_fail++; $display("FAIL simul_first: n=%0d ch=%0d rise=%b want ch=0 rise=1", n, o_evt_ch, o_evt_rise); end
    step(5);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd0) begin n_fail++; $display("FAIL simul_hold: valid=%b ch=%0d want 1/0", o_evt_valid, o_evt_ch); end
    n_checks++; if (o_level !== 4'b1101) begin n_fail++; $display("FAIL simul_level: got %b want 1101", o_level); end
    i_evt_ready = 1'b1;
    step(1);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd2) begin n_fail++; $display("FAIL simul_second: valid=%b ch=%0d want 1/2", o_evt_valid, o_evt_ch); end
    step(1);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd3) begin n_fail++; $display("FAIL simul_third: valid=%b ch=%0d want 1/3", o_evt_valid, o_evt_ch); end
    step(1);
    n_checks++; if (o_evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain: valid=%b want 0", o_evt_valid); end
    n_checks++; if (evq.size() != 3 || evq[0].ch != 4'd0 || evq[1].ch != 4'd2 || evq[2].ch != 4'd3) begin n_fail++; $display("FAIL simul_order: got %0d events, want 3 in order 0,2,3", evq.size()); end
  endtask

  task automatic test_clean_press();
    int n;
    i_evt_ready = 1'b1;
    evq.delete();
    i_data[1] = 1'b1;
    wait_lvl(1, 1'b1, n);
    n_checks++; if (n < 11 || n > 14) begin n_fail++; $display("FAIL press_latency: got %0d cycles want 11..14", n); end
    n_checks++; if (o_evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_valid_early: got %b want 0", o_evt_valid); end
    step(1);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd1 || o_evt_rise !== 1'b1) begin n_fail++; $display("FAIL press_event: valid=%b ch=%0d rise=%b want 1/1/1", o_evt_valid, o_evt_ch, o_evt_rise); end
    step(10);
    n_checks++; if (evq.size() != 1 || o_evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_single: events=%0d valid=%b want 1/0", evq.size(), o_evt_valid); end
    evq.delete();
    i_data[1] = 1'b0;
    step(30);
    n_checks++; if (o_level[1] !== 1'b0) begin n_fail++; $display("FAIL release_level: got %b want 0", o_level[1]); end
    n_checks++; if (evq.size() != REL_EVTS) begin n_fail++; $display("FAIL release_events: got %0d want %0d", evq.size(), REL_EVTS); end
  endtask

  task automatic test_bounce();
    int bad = 0;
    i_evt_ready = 1'b1;
    evq.delete();
    for (int c = 0; c < 40; c++) begin
      i_data[0] = ((c / 5) % 2 == 0);
      step(1);
      if (o_level[0] !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0 || evq.size() != 0) begin n_fail++; $display("FAIL bounce_quiet: level_hits=%0d events=%0d want 0/0", bad, evq.size()); end
    i_data[0] = 1'b1;
    step(30);
    n_checks++; if (o_level[0] !== 1'b1) begin n_fail++; $display("FAIL bounce_level: got %b want 1", o_level[0]); end
    n_checks++; if (evq.size() != 1 || evq[0].ch != 4'd0 || evq[0].rise != 1'b1) begin n_fail++; $display("FAIL bounce_event: got %0d events want one ch0 rise", evq.size()); end
  endtask

  task automatic test_overrun();
    int n;
    i_evt_ready = 1'b0;
    evq.delete();
    i_data[1] = 1'b1;
    wait_valid(n);
    n_checks++; if (n < 0 || o_evt_ch !== 2'd1) begin n_fail++; $display("FAIL ovr_occupy: n=%0d ch=%0d want ch=1", n, o_evt_ch); end
    i_data[2] = 1'b1;
    wait_lvl(2, 1'b1, n);
    n_checks++; if (n < 0 || o_overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_none_yet: n=%0d overrun=%b want 0000", n, o_overrun); end
    i_data[2] = 1'b0;
    wait_lvl(2, 1'b0, n);
`ifdef BUTTON_EVENT_ARBITER_RELEASE_EN
    n_checks++; if (n < 0 || o_overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_set: n=%0d overrun=%b want 0100", n, o_overrun); end
`else
    n_checks++; if (n < 0 || o_overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_release_ignored: n=%0d overrun=%b want 0000", n, o_overrun); end
    i_data[2] = 1'b1;
    wait_lvl(2, 1'b1, n);
    n_checks++; if (n < 0 || o_overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_set: n=%0d overrun=%b want 0100", n, o_overrun); end
`endif
    step(3);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd1) begin n_fail++; $display("FAIL ovr_hold: valid=%b ch=%0d want 1/1", o_evt_valid, o_evt_ch); end
    i_evt_ready = 1'b1;
    step(1);
    n_checks++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd2 || o_evt_rise !== OVR_RISE) begin n_fail++; $display("FAIL ovr_newer_pol: valid=%b ch=%0d rise=%b want 1/2/%b", o_evt_valid, o_evt_ch, o_evt_rise, OVR_RISE); end
    step(1);
    n_checks++; if (o_evt_valid !== 1'b0 || o_overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_sticky: valid=%b overrun=%b want 0/0100", o_evt_valid, o_overrun); end
    i_clr_overrun = 1'b1;
    step(1);
    i_clr_overrun = 1'b0;
    n_checks++; if (o_overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear: got %b want 0000", o_overrun); end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad = 0;
    i_evt_ready = 1'b0;
    evq.delete();
    i_data = 4'b0111;
    wait_valid(n);
    step(2);
    n_checks++; if (n < 0 || o_evt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: n=%0d valid=%b want 1", n, o_evt_valid); end
    i_rst = 1'b0;
    i_data = '0;
    step(2);
    n_checks++; if (o_evt_valid !== 1'b0 || o_evt_ch !== 2'd0 || o_evt_rise !== RST_RISE) begin n_fail++; $display("FAIL rst_mid_outputs: valid=%b ch=%0d rise=%b want 0/0/%b", o_evt_valid, o_evt_ch, o_evt_rise, RST_RISE); end
    n_checks++; if (o_level !== 4'b0000 || o_overrun !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_state: level=%b overrun=%b want 0000/0000", o_level, o_overrun); end
    evq.delete();
    i_rst = 1'b1;
    i_evt_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (o_evt_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0 || evq.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_replay: valid_cycles=%0d events=%0d want 0/0", bad, evq.size()); end
  endtask

  task automatic test_round_robin();
    int bad = 0;
    evq.delete();
    for (int c = 0; c < 400; c++) begin
      i_data[0] = ((c / 16) % 2 == 0);
      i_data[3] = ((c / 16) % 2 == 0);
      i_evt_ready = (c % 40 == 39);
      step(1);
    end
    i_evt_ready = 1'b0;
    n_checks++; if (evq.size() != 10) begin n_fail++; $display("FAIL rr_count: got %0d grants want 10", evq.size()); end
    foreach (evq[k]) begin
      if (evq[k].ch != ((k % 2 == 0) ? 4'd0 : 4'd3)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rr_alternate: %0d grants out of 0,3,0,3 order, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_simul_press();
    settle_all();
    test_clean_press();
    settle_all();
    test_bounce();
    settle_all();
    test_overrun();
    settle_all();
    test_reset_mid();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
